// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   - clr_state_e : clear sequencer state encoding
//   - DEF_*       : default parameter values for the register file
//   - port_slice  : pulls port k (w bits wide) out of a packed multi-port bus
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_NUM_RD = 2;

  // Widest packed bus / slice that port_slice handles (4 ports x 16 address bits).
  localparam int unsigned BUS_MAX   = 64;
  localparam int unsigned SLICE_MAX = 16;

  typedef enum logic {
    StIdle,
    StClear
  } clr_state_e;

  function automatic logic [SLICE_MAX-1:0] port_slice(input logic [BUS_MAX-1:0] packed_bus,
                                                      input int unsigned        k,
                                                      input int unsigned        w);
    logic [BUS_MAX-1:0]   shifted;
    logic [SLICE_MAX-1:0] mask;
    shifted = packed_bus >> (k * w);
    // For w == SLICE_MAX the shift yields 0 and the subtraction wraps to all ones.
    mask    = (SLICE_MAX'(1) << w) - SLICE_MAX'(1);
    return shifted[SLICE_MAX-1:0] & mask;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Bus interface of the multi-port register file.
//   master : write ports (we0/wa0/wd0, we1/wa1/wd1), packed read addresses ra, clr_req
//            driven; packed read data rd, busy, wr_drop received
//   slave  : the register file side (directions mirrored)
interface regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
);

  logic                     we0;
  logic [ADDR_W-1:0]        wa0;
  logic [DATA_W-1:0]        wd0;
  logic                     we1;
  logic [ADDR_W-1:0]        wa1;
  logic [DATA_W-1:0]        wd1;
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic                     clr_req;
  logic                     busy;
  logic                     wr_drop;

  modport master (
    output we0, wa0, wd0, we1, wa1, wd1, ra, clr_req,
    input  rd, busy, wr_drop
  );

  modport slave (
    input  we0, wa0, wd0, we1, wa1, wd1, ra, clr_req,
    output rd, busy, wr_drop
  );

endinterface

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer: sweeps every entry to zero, one per cycle, after a clr_req pulse.
//   clk, rst  : clock, asynchronous active-high reset
//   clr_req   : start a sweep (ignored while one is running)
//   we_any    : any write port enabled this cycle
//   busy      : sweep in progress
//   wr_drop   : registered pulse, a write was discarded in the previous cycle
//   clr_we    : storage clear strobe for entry clr_addr
//   clr_addr  : entry being cleared this cycle
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  input  logic              we_any,
  output logic              busy,
  output logic              wr_drop,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              drop_q, drop_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        drop_d = we_any;
        cnt_d  = cnt_q + ADDR_W'(1);
        // Last entry reached: the sweep ends here rather than wrapping around.
        if (cnt_q == '1) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q == StClear);
  assign clr_we   = (state_q == StClear);
  assign clr_addr = cnt_q;
  assign wr_drop  = drop_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered read ports, two write ports (port 1 wins on
// an address collision), optional hardwired-zero entry 0, and a multi-cycle clear sweep.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : regfile_if slave (write ports, packed ra/rd, clr_req, busy, wr_drop)
// Build option: REGFILE_BYPASS_EN - when defined, a read of an address written in the same
// cycle returns the new write data; otherwise the read returns the pre-write contents.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = DEF_NUM_RD,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DATA_W-1:0]        mem_d [DEPTH];
  logic [NUM_RD*DATA_W-1:0] rd_q, rd_d;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              busy;
  logic              wr_drop;
  logic              wr_en;

  regfile_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (bus.clr_req),
    .we_any   (bus.we0 | bus.we1),
    .busy     (busy),
    .wr_drop  (wr_drop),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Writes are only accepted outside a clear sweep.
  assign wr_en = ~clr_we;

  always_comb begin
    mem_d = mem_q;
    if (clr_we) begin
      mem_d[clr_addr] = '0;
    end else begin
      if (bus.we0) mem_d[bus.wa0] = bus.wd0;
      // Port 1 is applied last so it overrides port 0 on the same address.
      if (bus.we1) mem_d[bus.wa1] = bus.wd1;
    end
    if (ZERO_REG) mem_d[0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  logic [BUS_MAX-1:0] ra_wide;
  logic [ADDR_W-1:0]  raddr;
  logic [DATA_W-1:0]  rval;

  always_comb begin
    ra_wide                     = '0;
    ra_wide[NUM_RD*ADDR_W-1:0]  = bus.ra;
    rd_d                        = '0;
    raddr                       = '0;
    rval                        = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      raddr = ADDR_W'(port_slice(ra_wide, k, ADDR_W));
      rval  = mem_q[raddr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && bus.we1 && (bus.wa1 == raddr)) begin
        rval = bus.wd1;
      end else if (wr_en && bus.we0 && (bus.wa0 == raddr)) begin
        rval = bus.wd0;
      end
`endif
      if (ZERO_REG && (raddr == '0)) rval = '0;
      rd_d[k*DATA_W +: DATA_W] = rval;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign bus.rd      = rd_q;
  assign bus.busy    = busy;
  assign bus.wr_drop = wr_drop;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the MIPS datapath, the successor to the single-port-pair register file. It offers NUM_RD registered read ports and two clocked write ports with fixed priority. It also provides an optional hardwired-zero register and a multi-cycle clear sequencer with a busy handshake. It sits between decode (read addresses) and writeback (write ports), and serves the single-cycle core as well as planned dual-issue variants.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- we0  in  1  write enable, port 0
- wa0  in  ADDR_W  write address, port 0
- wd0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (higher priority)
- wa1  in  ADDR_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- ra  in  NUM_RD*ADDR_W  packed read addresses; port k = ra[k*ADDR_W +: ADDR_W]
- rd  out  NUM_RD*DATA_W  packed registered read data; port k = rd[k*DATA_W +: DATA_W]
- clr_req  in  1  single-cycle pulse requesting a clear of all entries
- busy  out  1  high while a clear sweep is in progress
- wr_drop  out  1  one-cycle pulse when a write is discarded during a clear

## Operation
- Reset, asynchronous: all entries = 0, rd = 0, busy = 0, wr_drop = 0, FSM = IDLE, sweep counter = 0.
- Write, IDLE state: the entry at wa is loaded with wd on the clock edge when we = 1.
  - we0 and we1 to the same address in the same cycle: wd1 is stored, wd0 is lost; no flag is raised.
- ZERO_REG = 1: writes to entry 0 are ignored and reads of entry 0 return 0.
- Read: each cycle, rd port k registers entry[ra_k].
  - Read during a same-cycle write to the same address: behaviour is selected by the macro (see Configuration).
- Clear FSM:
  - IDLE -> CLEAR on clr_req; the counter is set to 0 and busy goes high next cycle.
  - CLEAR: entry[cnt] is set to 0 and cnt increments, one entry per cycle.
  - CLEAR -> IDLE after entry DEPTH-1 is cleared; busy drops the same edge.
- During CLEAR:
  - Any we0/we1 is discarded and wr_drop pulses the next cycle, once per cycle regardless of how many ports wrote.
  - Reads remain live: entries already cleared return 0, the rest return old contents.
  - clr_req is ignored; it does not restart the sweep.
- rst asserted mid-sweep clears everything immediately and returns the FSM to IDLE.
- Counter width is ADDR_W; wrap at DEPTH-1 is terminal, not cyclic.

## Timing
- Write latency: data is visible in storage one edge after we.
- Read latency: 1 cycle; rd reflects the ra presented before the edge.
- Clear: clr_req at edge N. busy is high from N+1 through N+DEPTH; entry i is cleared at edge N+1+i; IDLE at N+DEPTH+1 cycle start. DEPTH = 32 gives 32 busy cycles.
- wr_drop: registered, asserted the cycle after the dropped write.
- No combinational path from inputs to any output.

## Configuration
- REGFILE_BYPASS_EN defined: on a same-cycle write and read of the same address, rd captures the write data. wd1 wins over wd0. ZERO_REG still forces 0 for entry 0. During CLEAR no bypass occurs, because the writes are dropped.
- REGFILE_BYPASS_EN undefined: rd captures the pre-write contents (read-before-write); the new value is seen one cycle later.

## Structure
- Shared package regfile_pkg:
  - clear FSM state enum (IDLE, CLEAR)
  - default parameter constants (DATA_W, ADDR_W, NUM_RD)
  - function to extract a packed port slice
- Sub-module regfile_clr_fsm:
  - contains the state register, sweep counter, busy and wr_drop generation
  - outputs clr_we and clr_addr to the storage array
- Storage array, write arbitration and read ports stay in regfile_mp.

## Test plan
- Reset, then write wa0=3, wd0=0x0000_0003; read ra0=3 next cycle -> rd0 = 0x0000_0003 one cycle later; read ra1=0 -> 0 (ZERO_REG=1).
- we0 and we1 both to address 7 with wd0=0xAAAA_AAAA, wd1=0x5555_5555 -> entry 7 reads 0x5555_5555.
- Write address 4 = 0x1234 while reading address 4 the same cycle -> rd = 0x1234 with REGFILE_BYPASS_EN, old value without it; next cycle 0x1234 in both builds.
- Fill all entries with 0xFFFF_FFFF, pulse clr_req -> busy high exactly 32 cycles; a write issued on busy-cycle 5 is dropped with wr_drop = 1; afterwards every entry reads 0.
- Assert rst at busy-cycle 10 -> busy = 0 and all rd = 0 immediately; a subsequent write and read of address 9 works normally.
- Write address 0 = 0xDEAD_BEEF with ZERO_REG=1 -> reads 0; with ZERO_REG=0 -> reads 0xDEAD_BEEF.
